// File: rtl/wfg_drive_dac_core.sv
// wfg_drive_dac_core: AXI-Stream sample sink that serialises each accepted sample as one SPI DAC write frame.
// Optional macro WFG_DRIVE_DAC_SYNC_EN: each accept additionally waits for a wfg_pat_sync_i pulse.
module wfg_drive_dac_core #(
  parameter int unsigned AXIS_W = 32,
  parameter int unsigned DIV_W  = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              ctrl_en_q_i,
  input  logic              ctrl_cpol_q_i,
  input  logic              ctrl_lsbfirst_q_i,
  input  logic [4:0]        ctrl_width_q_i,
  input  logic [DIV_W-1:0]  clkcfg_div_q_i,
  input  logic              wfg_pat_sync_i,
  output logic              wfg_drive_dac_tready_o,
  input  logic              wfg_drive_dac_tvalid_i,
  input  logic [AXIS_W-1:0] wfg_drive_dac_tdata_i,
  output logic              dac_sck_o,
  output logic              dac_cs_no,
  output logic              dac_mosi_o,
  output logic              busy_o
);

  localparam int unsigned SH_W = 32;
  localparam int unsigned BC_W = 6;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t            state_q;
  logic [DIV_W-1:0]  cnt_q;
  logic [DIV_W-1:0]  div_q;
  logic              cpol_q;
  logic              lsb_q;
  logic [BC_W-1:0]   bits_q;
  logic [BC_W-1:0]   bit_cnt_q;
  logic              ph_q;
  logic [SH_W-1:0]   sh_q;
  logic              cs_n_q;
  logic              mosi_q;
  logic              busy_q;

  logic [SH_W-1:0]   sample_c;
  logic              go_c;
  logic              accept_c;
  logic              tick_c;

  assign sample_c = SH_W'(wfg_drive_dac_tdata_i);
  assign tick_c   = (cnt_q == div_q);

`ifdef WFG_DRIVE_DAC_SYNC_EN
  logic pend_q;

  // Remember a sync pulse that arrived in IDLE before any sample was offered.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      pend_q <= 1'b0;
    end else if (accept_c) begin
      pend_q <= 1'b0;
    end else if (state_q == IDLE && wfg_pat_sync_i && !wfg_drive_dac_tvalid_i) begin
      pend_q <= 1'b1;
    end
  end

  assign go_c = wfg_pat_sync_i | pend_q;
`else
  logic unused_sync;
  assign unused_sync = wfg_pat_sync_i;
  assign go_c        = 1'b1;
`endif

  assign wfg_drive_dac_tready_o = ~wb_rst_i & ctrl_en_q_i & go_c & (state_q == IDLE);
  assign accept_c               = wfg_drive_dac_tready_o & wfg_drive_dac_tvalid_i;

  // SCK follows the live idle level outside a frame and the shadowed level inside it.
  assign dac_sck_o  = (state_q == IDLE) ? ctrl_cpol_q_i : (cpol_q ^ ph_q);
  assign dac_cs_no  = cs_n_q;
  assign dac_mosi_o = mosi_q;
  assign busy_o     = busy_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_q     <= '0;
      cpol_q    <= 1'b0;
      lsb_q     <= 1'b0;
      bits_q    <= '0;
      bit_cnt_q <= '0;
      ph_q      <= 1'b0;
      sh_q      <= '0;
      cs_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_c) begin
            state_q   <= SETUP;
            cs_n_q    <= 1'b0;
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            ph_q      <= 1'b0;
            div_q     <= clkcfg_div_q_i;
            cpol_q    <= ctrl_cpol_q_i;
            lsb_q     <= ctrl_lsbfirst_q_i;
            bits_q    <= BC_W'(ctrl_width_q_i) + BC_W'(1);
            // MSB-first pre-aligns bit W-1 to the top so bits above W-1 fall off.
            if (ctrl_lsbfirst_q_i) begin
              sh_q   <= sample_c;
              mosi_q <= sample_c[0];
            end else begin
              sh_q   <= sample_c << (5'd31 - ctrl_width_q_i);
              mosi_q <= sample_c[ctrl_width_q_i];
            end
          end
        end
        SETUP: begin
          if (tick_c) begin
            cnt_q   <= '0;
            state_q <= SHIFT;
          end else begin
            cnt_q <= cnt_q + DIV_W'(1);
          end
        end
        SHIFT: begin
          if (tick_c) begin
            cnt_q <= '0;
            ph_q  <= ~ph_q;
            if (ph_q) begin
              bit_cnt_q <= bit_cnt_q + BC_W'(1);
              if (bit_cnt_q + BC_W'(1) == bits_q) begin
                state_q <= HOLD;
              end else if (lsb_q) begin
                sh_q   <= {1'b0, sh_q[SH_W-1:1]};
                mosi_q <= sh_q[1];
              end else begin
                sh_q   <= {sh_q[SH_W-2:0], 1'b0};
                mosi_q <= sh_q[SH_W-2];
              end
            end
          end else begin
            cnt_q <= cnt_q + DIV_W'(1);
          end
        end
        HOLD: begin
          if (tick_c) begin
            cnt_q   <= '0;
            cs_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
            state_q <= GAP;
          end else begin
            cnt_q <= cnt_q + DIV_W'(1);
          end
        end
        GAP: begin
          if (tick_c) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + DIV_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
